mul_serial_ctrl: RTL and testbench
==================================

Name: mul_serial_ctrl

Overview:
Sequencer and shift-add accumulator wrapped around the binary-serial partial-product stage (mul_inner).
- Accepts one signed operand pair over a valid/ready handshake.
- Drives the operands, bit index, enable and clear into mul_inner, one bit per cycle, LSB first.
- Accumulates the returned partial products into a 2*WIDTH two's-complement product.
- Presents the product on a valid/ready output.

Parameters:
WIDTH, 16, operand width in bits
DEPTH, 4, index width; must equal clog2(WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
i_valid  in  1  operand pair valid
o_ready  out  1  block can accept operands (IDLE only)
i_a  in  WIDTH  signed multiplier, bit-scanned
i_b  in  WIDTH  signed multiplicand
o_data0  out  WIDTH  latched i_a, to mul_inner i_data0
o_data1  out  WIDTH  latched i_b, to mul_inner i_data1
o_idx  out  DEPTH  bit index, to mul_inner i_idx
o_en  out  1  index load enable, to mul_inner en
o_clr  out  1  index clear, to mul_inner clr
i_pp  in  2*WIDTH  partial product from mul_inner o_data (i_b or 0)
o_valid  out  1  product valid
i_ready  in  1  consumer accepts product
o_prod  out  2*WIDTH  signed product

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; cnt, pp_idx, pp_vld, acc, o_data0, o_data1 all 0.
- Reset outputs: o_ready=1, o_valid=0, o_prod=0, o_en=0, o_idx=0, o_clr=1.
- Reset mid-operation aborts the current product with no output.
- States: IDLE, ISSUE, DRAIN, DONE (enum from package).
- IDLE
  - o_ready=1, o_clr=1, o_en=0.
  - On i_valid & o_ready: latch i_a/i_b into o_data0/o_data1; acc<=0; cnt<=0; go to ISSUE.
- ISSUE
  - o_en=1, o_idx=cnt, o_clr=0; cnt increments each cycle.
  - When cnt==WIDTH-1, go to DRAIN.
  - Lasts exactly WIDTH cycles.
- Partial-product alignment
  - mul_inner registers the index, so i_pp for index k is valid the cycle after o_idx=k with o_en=1.
  - Registers pp_idx<=cnt and pp_vld<=(state==ISSUE) track this alignment.
- Accumulate when pp_vld=1, all arithmetic modulo 2^(2*WIDTH):
  - pp_idx<WIDTH-1: acc <= acc + (i_pp << pp_idx).
  - pp_idx==WIDTH-1: acc <= acc - (i_pp << (WIDTH-1)), giving the MSB its negative two's-complement weight.
  - i_pp is sign-extended i_b; shift is logical within 2*WIDTH, overflow discarded. The result is exact for all signed inputs.
- DRAIN: one cycle, absorbs the final partial product; go to DONE.
- DONE
  - o_valid=1; o_prod=acc, held stable while i_ready=0.
  - On i_ready: go to IDLE; o_prod keeps its value.
  - No new accept in the same cycle; back-to-back throughput is one product per WIDTH+3 cycles.
- Latency: accept at cycle T, o_valid first high at T+WIDTH+2.
- o_data0/o_data1 stay stable from accept until return to IDLE.
- i_valid in non-IDLE states is ignored; upstream must hold it until o_ready.

Optional Feature:
MUL_SERIAL_ZERO_SKIP_EN
- Defined: at accept, if i_a==0 or i_b==0, skip ISSUE/DRAIN and go to DONE with acc=0. o_valid rises at T+1; o_en stays 0.
- Undefined: every operand pair takes the full WIDTH+2 latency.

Decomposition:
- Package mul_serial_pkg holds:
  - mul_serial_state_t enum {IDLE, ISSUE, DRAIN, DONE}
  - constant default WIDTH=16, DEPTH=4
- One sub-module, mul_serial_shacc: registered shift/add/subtract accumulator with inputs clr, pp_vld, pp_idx, i_pp, output acc.
- FSM, counter and handshake stay in the top module.

Test Plan:
- With mul_inner attached, a=3, b=5 -> o_prod=0x0000000F; o_valid exactly 18 cycles after accept; o_idx sweeps 0..15 with o_en high 16 cycles.
- a=-3 (0xFFFD), b=5 -> 0xFFFFFFF1; a=5, b=-3 -> 0xFFFFFFF1 (tests MSB-subtract and sign-extended i_pp).
- a=b=-32768 (0x8000) -> 0x40000000; a=-32768, b=32767 -> 0xC0008000.
- Back-pressure: i_ready=0 for 5 cycles in DONE -> o_valid and o_prod stable, o_ready=0, new i_valid ignored; product accepted on i_ready=1, o_ready=1 next cycle.
- Reset at ISSUE cnt=7 -> next cycle IDLE, o_valid=0, o_clr=1, o_ready=1; the following 7*9 returns 0x0000003F.
- a=0, b=1234 -> 0; with MUL_SERIAL_ZERO_SKIP_EN o_valid at accept+1, without it at accept+18; random 1000-pair signed sweep matches a*b.

Source files
------------

// File: rtl/mul_serial_pkg.sv
// Shared types and default sizing for the serial multiplier controller.
package mul_serial_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mul_serial_state_t;

endpackage

// File: rtl/mul_serial_shacc.sv
// Shift/add/subtract accumulator: folds one aligned partial product per cycle
// into a 2*WIDTH two's-complement sum. The top bit index carries negative weight.
import mul_serial_pkg::*;

module mul_serial_shacc #(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               pp_vld,
    input  logic [DEPTH-1:0]   pp_idx,
    input  logic [2*WIDTH-1:0] i_pp,
    output logic [2*WIDTH-1:0] acc
);

    localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] shifted;

    // Next accumulator value; arithmetic wraps modulo 2^(2*WIDTH).
    always_comb begin
        shifted = i_pp << pp_idx;
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (pp_vld) begin
            if (pp_idx == LAST_IDX) begin
                acc_d = acc_q - shifted;
            end else begin
                acc_d = acc_q + shifted;
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mul_serial_ctrl.sv
// Sequencer around the bit-serial partial-product stage (mul_inner): accepts a
// signed operand pair, scans i_a LSB first, accumulates the returned partial
// products and presents the 2*WIDTH signed product.
// Optional: define MUL_SERIAL_ZERO_SKIP_EN to bypass the scan when an operand is 0.
import mul_serial_pkg::*;

module mul_serial_ctrl #(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   o_data0,
    output logic [WIDTH-1:0]   o_data1,
    output logic [DEPTH-1:0]   o_idx,
    output logic               o_en,
    output logic               o_clr,
    input  logic [2*WIDTH-1:0] i_pp,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(WIDTH - 1);

    mul_serial_state_t  state_q, state_d;
    logic [DEPTH-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]   pp_idx_q;
    logic               pp_vld_q;
    logic [WIDTH-1:0]   data0_q, data1_q;
    logic               accept;
    logic               skip;
    logic [2*WIDTH-1:0] acc;

    assign accept = (state_q == IDLE) && i_valid;

`ifdef MUL_SERIAL_ZERO_SKIP_EN
    assign skip = (i_a == '0) || (i_b == '0);
`else
    assign skip = 1'b0;
`endif

    // Next-state, counter and handshake/driver outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_ready = 1'b0;
        o_en    = 1'b0;
        o_clr   = 1'b0;
        o_idx   = '0;
        o_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                o_clr   = 1'b1;
                if (i_valid) begin
                    cnt_d   = '0;
                    state_d = skip ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                o_en  = 1'b1;
                o_idx = cnt_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Final partial product lands this cycle.
                state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, alignment and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pp_idx_q <= '0;
            pp_vld_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // mul_inner registers the index, so its answer arrives one cycle later.
            pp_idx_q <= cnt_q;
            pp_vld_q <= (state_q == ISSUE);
            if (accept) begin
                data0_q <= i_a;
                data1_q <= i_b;
            end
        end
    end

    mul_serial_shacc #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_shacc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .pp_vld (pp_vld_q),
        .pp_idx (pp_idx_q),
        .i_pp   (i_pp),
        .acc    (acc)
    );

    assign o_data0 = data0_q;
    assign o_data1 = data1_q;
    assign o_prod  = acc;

endmodule

// File: tb/tb_mul_serial_ctrl.sv
// Scoreboard bench for mul_serial_ctrl with a behavioural mul_inner attached.
module tb_mul_serial_ctrl;

    localparam int W = 16;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b1;
    logic [W-1:0]   i_a = '0;
    logic [W-1:0]   i_b = '0;
    logic           o_ready;
    logic [W-1:0]   o_data0;
    logic [W-1:0]   o_data1;
    logic [D-1:0]   o_idx;
    logic           o_en;
    logic           o_clr;
    logic [2*W-1:0] pp;
    logic           o_valid;
    logic [2*W-1:0] o_prod;

    always #5 clk = ~clk;

    mul_serial_ctrl #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_data0 (o_data0),
        .o_data1 (o_data1),
        .o_idx   (o_idx),
        .o_en    (o_en),
        .o_clr   (o_clr),
        .i_pp    (pp),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_prod  (o_prod)
    );

    // Partial-product stage: registered index, output is sign-extended i_data1 or 0.
    logic [D-1:0] inner_idx;
    always_ff @(posedge clk) begin
        if (rst || o_clr) inner_idx <= '0;
        else if (o_en)    inner_idx <= o_idx;
    end
    assign pp = o_data0[inner_idx] ? {{W{o_data1[W-1]}}, o_data1} : '0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             n_en;
        int             acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   issued = 0;
    int   outputs_seen = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Reference: exact signed product, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:0];
    endfunction

    function automatic bit is_skip(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SERIAL_ZERO_SKIP_EN
        return (a == '0) || (b == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Present one pair and wait for its handshake; returns 1 cycle after accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (!o_ready) begin
            if (n == 300) begin
                fail("ready_timeout");
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        e.prod    = ref_mul(a, b);
        e.lat     = is_skip(a, b) ? 1 : W + 2;
        e.n_en    = is_skip(a, b) ? 0 : W;
        e.acc_cyc = cyc - 1;
        sb.push_back(e);
        issued++;
        check("data0_latched", o_data0, a);
        check("data1_latched", o_data1, b);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 || !o_ready) begin
            if (n == 500) begin
                fail("drain_timeout");
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Monitor: index sweep, latency, enable count and product, sampled on negedge.
    initial begin
        bit   prev_valid;
        int   en_cnt;
        exp_t e;
        prev_valid = 1'b0;
        en_cnt     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                en_cnt     = 0;
                continue;
            end
            if (o_clr) begin
                en_cnt = 0;
            end else if (o_en) begin
                check("idx_sweep", o_idx, en_cnt);
                en_cnt++;
            end
            if (o_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    fail("unexpected_valid");
                end else begin
                    check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    check("en_cycles", en_cnt, sb[0].n_en);
                end
            end
            if (o_valid && i_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("product", o_prod, e.prod);
                outputs_seen++;
            end
            prev_valid = o_valid;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ta[6];
        logic [W-1:0] tb[6];
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] bp_exp;
        int n;

        ta = '{16'd3, 16'hFFFD, 16'd5, 16'h8000, 16'h8000, 16'd0};
        tb = '{16'd5, 16'd5, 16'hFFFD, 16'h8000, 16'h7FFF, 16'd1234};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_prod", o_prod, 0);
        check("rst_en", o_en, 0);
        check("rst_idx", o_idx, 0);
        check("rst_clr", o_clr, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed pairs, including MSB-weight and zero-operand corners.
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i]);
            wait_drain();
        end

        // Back-pressure in DONE: held output, no accept, late i_valid ignored.
        i_ready = 1'b0;
        bp_exp  = ref_mul(16'd1000, 16'hFFF9);
        issue(16'd1000, 16'hFFF9);
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_valid) fail("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", o_valid, 1);
            check("bp_prod_held", o_prod, bp_exp);
            check("bp_not_ready", o_ready, 0);
            i_valid = 1'b1;
            i_a     = 16'(($urandom % 65535) + 1);
            i_b     = 16'd77;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after", o_ready, 1);
        check("bp_valid_after", o_valid, 0);
        check("bp_prod_kept", o_prod, bp_exp);
        wait_drain();

        // Reset in the middle of ISSUE aborts the product.
        issue(16'd123, 16'd456);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("mid_idx", o_idx, 7);
        check("mid_en", o_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        issued--;
        check("abort_valid", o_valid, 0);
        check("abort_clr", o_clr, 1);
        check("abort_ready", o_ready, 1);
        issue(16'd7, 16'd9);
        wait_drain();

        // Randomized signed sweep with occasional corner operands.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(15) == 0) ra = '0;
            if ($urandom_range(15) == 0) rb = 16'h8000;
            if ($urandom_range(15) == 0) ra = 16'h7FFF;
            issue(ra, rb);
        end
        wait_drain();
        check("output_count", outputs_seen, issued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
